// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {GAP, WAIT, DONE, FAULT} reset_seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Stage index width; a single stage still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return max_int(1, $clog2(n));
    endfunction

    // One counter serves both the release gap and the ack timeout.
    function automatic int cnt_width(input int gap, input int timeout);
        return $clog2(max_int(gap, timeout) + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Releases downstream reset domains one at a time in index order, waiting a fixed
// gap before each release and a bounded ready handshake after it.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int                   NumStages        = 4,
    parameter int                   StageGapCycles   = 16,
    parameter int                   AckTimeoutCycles = 1024,
    parameter logic [NumStages-1:0] AckMask          = '1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    output logic [NumStages-1:0]                  stage_rst,
    input  logic [NumStages-1:0]                  stage_ready,
    output logic                                  seq_active,
    output logic                                  all_ready,
    output logic                                  timeout_err,
    output logic [idx_width(NumStages)-1:0]       failed_stage
);

    localparam int IdxW = idx_width(NumStages);
    localparam int CntW = cnt_width(StageGapCycles, AckTimeoutCycles);

    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumStages - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(StageGapCycles - 1);
    localparam logic [CntW-1:0] AckLast = CntW'(AckTimeoutCycles - 1);

    if (NumStages < 1) begin : g_bad_num_stages
        $error("reset_sequencer: NumStages must be >= 1");
    end
    if (StageGapCycles < 1) begin : g_bad_gap
        $error("reset_sequencer: StageGapCycles must be >= 1");
    end
    if (AckTimeoutCycles < 1) begin : g_bad_timeout
        $error("reset_sequencer: AckTimeoutCycles must be >= 1");
    end

    reset_seq_state_e state;
    logic [IdxW-1:0]  idx;
    logic [CntW-1:0]  cnt;
    logic             ack_ok;

    // Stages without a handshake are treated as permanently ready.
    assign ack_ok = stage_ready[idx] | ~AckMask[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= GAP;
            idx          <= '0;
            cnt          <= '0;
            stage_rst    <= '1;
            seq_active   <= 1'b0;
            all_ready    <= 1'b0;
            timeout_err  <= 1'b0;
            failed_stage <= '0;
        end else begin
            unique case (state)
                GAP: begin
                    seq_active <= 1'b1;
                    if (cnt == GapLast) begin
                        stage_rst[idx] <= 1'b0;
                        cnt            <= '0;
                        state          <= WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (ack_ok) begin
                        cnt <= '0;
                        if (idx == IdxLast) begin
                            all_ready  <= 1'b1;
                            seq_active <= 1'b0;
                            state      <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= GAP;
                        end
                    end else if (cnt == AckLast) begin
                        timeout_err  <= 1'b1;
                        failed_stage <= idx;
                        seq_active   <= 1'b0;
                        cnt          <= '0;
                        state        <= FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Terminal states hold every output until the next rst.
                DONE, FAULT: begin
                    seq_active <= 1'b0;
                end
                default: begin
                    state <= GAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed vectors plus randomized traffic
// compared against a timestamp-based reference model.
module tb_reset_sequencer;

    localparam int N  = 4;
    localparam int G  = 4;
    localparam int AT = 8;
    localparam logic [3:0] MASK_A = 4'b1111;
    localparam logic [3:0] MASK_B = 4'b0101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ready = '0;
    logic [3:0] ready_m = '0;

    logic [3:0] srst, srst_m;
    logic       act, act_m, allr, allr_m, terr, terr_m;
    logic [1:0] fst, fst_m;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.NumStages(N), .StageGapCycles(G), .AckTimeoutCycles(AT), .AckMask(MASK_A)) u_dut (
        .clk(clk), .rst(rst), .stage_rst(srst), .stage_ready(ready),
        .seq_active(act), .all_ready(allr), .timeout_err(terr), .failed_stage(fst)
    );

    reset_sequencer #(.NumStages(N), .StageGapCycles(G), .AckTimeoutCycles(AT), .AckMask(MASK_B)) u_dut_m (
        .clk(clk), .rst(rst), .stage_rst(srst_m), .stage_ready(ready_m),
        .seq_active(act_m), .all_ready(allr_m), .timeout_err(terr_m), .failed_stage(fst_m)
    );

    // Reference model: tracks when the current stage is due for release (absolute edge
    // number) and how long it has been out of reset, rather than a state machine.
    typedef struct packed {
        logic [3:0] rst_bits;
        logic       act;
        logic       all;
        logic       err;
        logic [1:0] fst;
        logic       over;
        logic       started;
        logic       released;
        int         stage;
        int         rel_edge;
    } model_t;

    model_t m_a = '0;
    model_t m_b = '0;
    int     edge_cnt = 0;
    bit     armed = 1'b0;

    function automatic model_t model_next(input model_t s, input logic r, input logic [3:0] rdy,
                                          input logic [3:0] mask, input int t);
        model_t     n;
        logic [3:0] bits;
        n = s;
        if (r) begin
            n = '0;
            n.rst_bits = 4'hF;
        end else if (!s.over) begin
            if (!n.started) begin
                n.started  = 1'b1;
                n.rel_edge = t + G - 1;
            end
            n.act = 1'b1;
            if (!n.released) begin
                if (t == n.rel_edge) begin
                    bits = n.rst_bits;
                    bits[n.stage] = 1'b0;
                    n.rst_bits = bits;
                    n.released = 1'b1;
                end
            end else if (rdy[n.stage] || !mask[n.stage]) begin
                if (n.stage == N - 1) begin
                    n.all  = 1'b1;
                    n.over = 1'b1;
                    n.act  = 1'b0;
                end else begin
                    n.stage    = n.stage + 1;
                    n.released = 1'b0;
                    n.rel_edge = t + G;
                end
            end else if (t - n.rel_edge == AT) begin
                n.err  = 1'b1;
                n.fst  = 2'(n.stage);
                n.over = 1'b1;
                n.act  = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m_a      <= model_next(m_a, rst, ready, MASK_A, edge_cnt);
        m_b      <= model_next(m_b, rst, ready_m, MASK_B, edge_cnt);
        edge_cnt <= edge_cnt + 1;
        armed    <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("model_a", {23'd0, srst, act, allr, terr, fst},
                {23'd0, m_a.rst_bits, m_a.act, m_a.all, m_a.err, m_a.fst});
            chk("model_b", {23'd0, srst_m, act_m, allr_m, terr_m, fst_m},
                {23'd0, m_b.rst_bits, m_b.act, m_b.all, m_b.err, m_b.fst});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] bundle(input logic [3:0] r, input logic a, input logic al,
                                           input logic e, input logic [1:0] f);
        return {23'd0, r, a, al, e, f};
    endfunction

    typedef struct packed {
        int         k;
        logic [3:0] rdy;
        logic [3:0] exp_rst;
        logic       exp_act;
        logic       exp_all;
        logic       exp_err;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int k_now;

        // Always-ready sequence: releases land at edges 3, 8, 13, 18; all_ready at 19.
        tbl[0]  = '{k: 0,  rdy: 4'hF, exp_rst: 4'b1111, exp_act: 1, exp_all: 0, exp_err: 0};
        tbl[1]  = '{k: 2,  rdy: 4'hF, exp_rst: 4'b1111, exp_act: 1, exp_all: 0, exp_err: 0};
        tbl[2]  = '{k: 3,  rdy: 4'hF, exp_rst: 4'b1110, exp_act: 1, exp_all: 0, exp_err: 0};
        tbl[3]  = '{k: 7,  rdy: 4'hF, exp_rst: 4'b1110, exp_act: 1, exp_all: 0, exp_err: 0};
        tbl[4]  = '{k: 8,  rdy: 4'hF, exp_rst: 4'b1100, exp_act: 1, exp_all: 0, exp_err: 0};
        tbl[5]  = '{k: 12, rdy: 4'hF, exp_rst: 4'b1100, exp_act: 1, exp_all: 0, exp_err: 0};
        tbl[6]  = '{k: 13, rdy: 4'hF, exp_rst: 4'b1000, exp_act: 1, exp_all: 0, exp_err: 0};
        tbl[7]  = '{k: 17, rdy: 4'hF, exp_rst: 4'b1000, exp_act: 1, exp_all: 0, exp_err: 0};
        tbl[8]  = '{k: 18, rdy: 4'hF, exp_rst: 4'b0000, exp_act: 1, exp_all: 0, exp_err: 0};
        tbl[9]  = '{k: 19, rdy: 4'hF, exp_rst: 4'b0000, exp_act: 0, exp_all: 1, exp_err: 0};
        tbl[10] = '{k: 25, rdy: 4'h0, exp_rst: 4'b0000, exp_act: 0, exp_all: 1, exp_err: 0};
        tbl[11] = '{k: 30, rdy: 4'h5, exp_rst: 4'b0000, exp_act: 0, exp_all: 1, exp_err: 0};

        // Reset state and ack-two-cycles-after-release sequence.
        rst = 1'b1;
        ready = '0;
        repeat (5) step();
        chk("reset_state", bundle(srst, act, allr, terr, fst), bundle(4'hF, 0, 0, 0, 2'd0));
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            w = 0;
            while (srst[i] !== 1'b0 && w < 40) begin
                step();
                w++;
            end
            chk("t1_release_pattern", {28'd0, srst}, (32'hF << (i + 1)) & 32'hF);
            chk("t1_release_gap", w, (i == 0) ? G : G + 1);
            step();
            ready[i] = 1'b1;
            chk("t1_not_done_yet", {31'd0, allr}, 32'd0);
        end
        step();
        chk("t1_all_ready", bundle(srst, act, allr, terr, fst), bundle(4'h0, 0, 1, 0, 2'd0));

        // Table-driven: ready held high from before reset release.
        ready = 4'hF;
        do_reset(2);
        k_now = -1;
        for (int v = 0; v < 12; v++) begin
            while (k_now < tbl[v].k) begin
                step();
                k_now++;
            end
            ready = tbl[v].rdy;
            chk($sformatf("t2_vec%0d", v), {28'd0, srst, act, allr, terr},
                {28'd0, tbl[v].exp_rst, tbl[v].exp_act, tbl[v].exp_all, tbl[v].exp_err});
        end

        // Stage 2 never acknowledges: fault at edge 13 + 8 = 21.
        ready = 4'b1011;
        do_reset(2);
        for (int k = 0; k <= 21; k++) begin
            step();
            if (k == 20) chk("t3_no_err_before_deadline", {31'd0, terr}, 32'd0);
        end
        chk("t3_fault", bundle(srst, act, allr, terr, fst), bundle(4'b1000, 0, 0, 1, 2'd2));
        for (int k = 0; k < 100; k++) begin
            ready = 4'($urandom);
            step();
            chk("t3_fault_hold", bundle(srst, act, allr, terr, fst), bundle(4'b1000, 0, 0, 1, 2'd2));
        end

        // Reset out of FAULT, then a clean run.
        rst = 1'b1;
        step();
        chk("t6_fault_cleared", bundle(srst, act, allr, terr, fst), bundle(4'hF, 0, 0, 0, 2'd0));
        rst = 1'b0;
        ready = 4'hF;
        w = 0;
        while (allr !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        chk("t6_done_latency", w, 20);
        chk("t6_done", bundle(srst, act, allr, terr, fst), bundle(4'h0, 0, 1, 0, 2'd0));

        // Mid-sequence reset while stage 1 waits, with an early stage-3 ready pulse.
        ready = '0;
        do_reset(2);
        repeat (4) step();
        chk("t5_stage0_released", {28'd0, srst}, 32'hE);
        ready = 4'b1000;
        repeat (2) step();
        chk("t5_wrong_ready_ignored", {28'd0, srst, act}, {28'd0, 4'hE, 1'b1});
        ready = 4'b0001;
        step();
        ready = '0;
        repeat (4) step();
        chk("t5_stage1_released", {28'd0, srst}, 32'hC);
        step();
        rst = 1'b1;
        step();
        chk("t5_mid_reset", bundle(srst, act, allr, terr, fst), bundle(4'hF, 0, 0, 0, 2'd0));
        rst = 1'b0;
        ready = 4'b1000;
        repeat (4) step();
        chk("t5_restart_stage0", {28'd0, srst, act, allr}, {28'd0, 4'hE, 1'b1, 1'b0});
        ready = 4'hF;
        w = 0;
        while (allr !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        chk("t5_rerun_done", bundle(srst, act, allr, terr, fst), bundle(4'h0, 0, 1, 0, 2'd0));

        // Masked instance: only stages 0 and 2 handshake.
        ready = '0;
        ready_m = 4'b0101;
        do_reset(2);
        for (int k = 0; k <= 19; k++) begin
            step();
            if (k == 18) chk("t4_not_done_at_18", {31'd0, allr_m}, 32'd0);
        end
        chk("t4_masked_done", bundle(srst_m, act_m, allr_m, terr_m, fst_m), bundle(4'h0, 0, 1, 0, 2'd0));

        // Randomized traffic, including occasional resets, checked by the model.
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 79) == 0);
            ready   = 4'($urandom) & 4'($urandom);
            ready_m = 4'($urandom) & 4'($urandom);
            step();
        end

        rst = 1'b1;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
